pipelined_cla_adder: RTL and testbench

//  Parametrised, pipelined carry-look-ahead add/subtract unit; successor to the combinational 8-bit CLA.

---
 rtl/pipelined_cla_adder.sv | 211 +++++++++++++++++++++
 tb/tb_pipelined_cla_adder.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder
//   Pipelined carry-look-ahead add/subtract unit with valid/ready streams on
//   both sides. The operand word is split into STAGES slices of SLICE bits.
//   Stage s adds slice s using BLOCK-bit look-ahead groups. Its carry reaches
//   stage s+1 through a pipeline register. Upper operand bits travel down the
//   pipe with the beat, and finished lower result bits travel with it too, so
//   one beat stays aligned. Latency is STAGES cycles when there are no stalls.
//
//   Optional feature: define CLA_SATURATE_EN to add the sat_mode/sat_hit ports
//   and the output clamp. The clamp sits in the last stage.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_valid/in_ready   operand handshake (in_ready = !out_valid | out_ready)
//   a, b, cin, sub      sub=0: a+b+cin ; sub=1: a-b-cin
//   out_valid/out_ready result handshake
//   sum, cout, ovf      result, raw carry out of MSB, signed overflow
//   sat_mode, sat_hit   [CLA_SATURATE_EN] 00/11 none, 01 unsigned, 10 signed;
//                       sat_hit is high when the result was clamped
module pipelined_cla_adder #(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
`ifdef CLA_SATURATE_EN
  ,
  input  logic [1:0]       sat_mode,
  output logic             sat_hit
`endif
);

  localparam int SLICE = WIDTH / STAGES;
  localparam int unsigned NGRP = SLICE / BLOCK;
  localparam int unsigned UBLK = BLOCK;

  logic advance;

  // SLICE-bit add built from look-ahead groups. Each bit carry inside a group
  // comes from the prefix generate/propagate terms and the group carry-in.
  // The group carry-out then feeds the next group of the slice.
  // Returns {carry_out, sum}.
  function automatic logic [SLICE:0] slice_add(input logic [SLICE-1:0] x,
                                               input logic [SLICE-1:0] y,
                                               input logic             ci);
    logic [SLICE-1:0] g, p;
    logic [SLICE:0]   c;
    logic             pg, pp;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = ci;
    for (int unsigned k = 0; k < NGRP; k++) begin
      for (int unsigned i = 1; i <= UBLK; i++) begin
        pg = 1'b0;
        pp = 1'b1;
        for (int unsigned j = 0; j < i; j++) begin
          pg = g[k*UBLK+j] | (p[k*UBLK+j] & pg);
          pp = pp & p[k*UBLK+j];
        end
        c[k*UBLK+i] = pg | (pp & c[k*UBLK]);
      end
    end
    return {c[SLICE], p ^ c[SLICE-1:0]};
  endfunction

  genvar s;
  generate
    for (s = 0; s < STAGES; s++) begin : stg
      localparam int UW = WIDTH - s*SLICE;   // operand bits still to be added
      localparam int RW = (s+1)*SLICE;       // result bits known after this stage

      logic [UW-1:0]    xa, xb;              // b already conditionally inverted
      logic             xc, xv;
`ifdef CLA_SATURATE_EN
      logic             xsub;
      logic [1:0]       xmode;
`endif
      logic [SLICE:0]   r;
      logic [RW-1:0]    nres, fres;
      logic [RW-1:0]    res_q;
      logic             c_q, vld_q;

      if (s == 0) begin : src
        assign xa = a;
        assign xb = b ^ {WIDTH{sub}};
        assign xc = cin ^ sub;               // subtract: a + ~b + !cin
        assign xv = in_valid;
`ifdef CLA_SATURATE_EN
        assign xsub  = sub;
        assign xmode = sat_mode;
`endif
        assign nres = r[SLICE-1:0];
      end else begin : src
        assign xa = stg[s-1].fwd.opa_q;
        assign xb = stg[s-1].fwd.opb_q;
        assign xc = stg[s-1].c_q;
        assign xv = stg[s-1].vld_q;
`ifdef CLA_SATURATE_EN
        assign xsub  = stg[s-1].fwd.sub_q;
        assign xmode = stg[s-1].fwd.mode_q;
`endif
        assign nres = {r[SLICE-1:0], stg[s-1].res_q};
      end

      assign r = slice_add(xa[SLICE-1:0], xb[SLICE-1:0], xc);

      if (s < STAGES-1) begin : fwd
        logic [UW-SLICE-1:0] opa_q, opb_q;
`ifdef CLA_SATURATE_EN
        logic                sub_q;
        logic [1:0]          mode_q;
`endif
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            opa_q  <= '0;
            opb_q  <= '0;
`ifdef CLA_SATURATE_EN
            sub_q  <= 1'b0;
            mode_q <= '0;
`endif
          end else if (advance) begin
            opa_q  <= xa[UW-1:SLICE];
            opb_q  <= xb[UW-1:SLICE];
`ifdef CLA_SATURATE_EN
            sub_q  <= xsub;
            mode_q <= xmode;
`endif
          end
        end
        assign fres = nres;
      end else begin : fin
        logic ovf_n, ovf_q;
        // carry into the MSB, recovered from the MSB sum bit and operand bits
        assign ovf_n = r[SLICE] ^ (nres[WIDTH-1] ^ xa[SLICE-1] ^ xb[SLICE-1]);
`ifdef CLA_SATURATE_EN
        logic hit, sat_q;
        always_comb begin
          fres = nres;
          hit  = 1'b0;
          case (xmode)
            2'b01: begin
              if (!xsub && r[SLICE]) begin
                fres = '1;
                hit  = 1'b1;
              end else if (xsub && !r[SLICE]) begin
                fres = '0;
                hit  = 1'b1;
              end
            end
            2'b10: begin
              // on overflow the true sign is the opposite of the wrapped MSB
              if (ovf_n) begin
                fres = nres[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                     : {1'b1, {(WIDTH-1){1'b0}}};
                hit  = 1'b1;
              end
            end
            default: ;
          endcase
        end
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)       sat_q <= 1'b0;
          else if (advance) sat_q <= hit;
        end
`else
        assign fres = nres;
`endif
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)       ovf_q <= 1'b0;
          else if (advance) ovf_q <= ovf_n;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          res_q <= '0;
          c_q   <= 1'b0;
          vld_q <= 1'b0;
        end else if (advance) begin
          res_q <= fres;
          c_q   <= r[SLICE];
          vld_q <= xv;
        end
      end
    end
  endgenerate

  assign out_valid = stg[STAGES-1].vld_q;
  assign sum       = stg[STAGES-1].res_q;
  assign cout      = stg[STAGES-1].c_q;
  assign ovf       = stg[STAGES-1].fin.ovf_q;
`ifdef CLA_SATURATE_EN
  assign sat_hit   = stg[STAGES-1].fin.sat_q;
`endif
  assign advance   = !out_valid | out_ready;
  assign in_ready  = advance;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed bench for pipelined_cla_adder (WIDTH=32, BLOCK=4, STAGES=2).
module tb_pipelined_cla_adder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] a, b;
  logic        cin, sub;
  logic        out_valid, out_ready;
  logic [31:0] sum;
  logic        cout, ovf;
`ifdef CLA_SATURATE_EN
  logic [1:0]  sat_mode;
  logic        sat_hit;
`endif

  int tests = 0;
  int fails = 0;

  pipelined_cla_adder #(.WIDTH(32), .BLOCK(4), .STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
`ifdef CLA_SATURATE_EN
    ,
    .sat_mode  (sat_mode),
    .sat_hit   (sat_hit)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One isolated beat: checks latency, then the result, then pops it.
  task automatic run_one(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                         input logic tc, input logic ts, input logic [1:0] tm,
                         input logic [31:0] es, input logic ec, input logic eo,
                         input logic esat);
    a = ta; b = tb_; cin = tc; sub = ts;
`ifdef CLA_SATURATE_EN
    sat_mode = tm;
`endif
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, ".early"}, {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".sum"},   sum, es);
    chk({tag, ".cout"},  {31'd0, cout}, {31'd0, ec});
    chk({tag, ".ovf"},   {31'd0, ovf},  {31'd0, eo});
`ifdef CLA_SATURATE_EN
    chk({tag, ".sat"},   {31'd0, sat_hit}, {31'd0, esat});
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
`ifdef CLA_SATURATE_EN
    sat_mode = 2'b00;
`endif
    #1;
    chk("rst.valid", {31'd0, out_valid}, 32'd0);
    chk("rst.sum",   sum, 32'd0);
    chk("rst.cout",  {31'd0, cout}, 32'd0);
    chk("rst.ovf",   {31'd0, ovf},  32'd0);
    #20 rst_n = 1'b1;
    #1;
    chk("rst.in_ready", {31'd0, in_ready}, 32'd1);

    // arithmetic vectors
    run_one("add_wrap",  32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 2'b00, 32'h0,         1'b1, 1'b0, 1'b0);
    run_one("add_ovf",   32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 2'b00, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run_one("add_cin",   32'h0,         32'h0, 1'b1, 1'b0, 2'b00, 32'h1,         1'b0, 1'b0, 1'b0);
    run_one("sub_neg",   32'h5,         32'h7, 1'b0, 1'b1, 2'b00, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_one("sub_bin",   32'h7,         32'h5, 1'b1, 1'b1, 2'b00, 32'h1,         1'b1, 1'b0, 1'b0);
    run_one("slice_cy",  32'h0000_FFFF, 32'h1, 1'b0, 1'b0, 2'b00, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
    run_one("sub_ovf",   32'h8000_0000, 32'h1, 1'b0, 1'b1, 2'b00, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    run_one("add_mix",   32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 2'b00, 32'h2222_2222, 1'b0, 1'b0, 1'b0);

    // streaming with a 3-cycle output stall
    a = 32'd1; b = 32'd1; cin = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    a = 32'd2; b = 32'd2; out_ready = 1'b0;
    @(posedge clk); #1;
    chk("strm.v1",    {31'd0, out_valid}, 32'd1);
    chk("strm.s1",    sum, 32'd2);
    chk("strm.rdy1",  {31'd0, in_ready}, 32'd0);
    a = 32'd3; b = 32'd3;
    @(posedge clk); #1;
    chk("strm.hold1", sum, 32'd2);
    chk("strm.rdy2",  {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("strm.hold2", sum, 32'd2);
    chk("strm.vhold", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    #1;
    chk("strm.rdy3",  {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    chk("strm.s2",    sum, 32'd4);
    a = 32'd4; b = 32'd4;
    @(posedge clk); #1;
    chk("strm.s3",    sum, 32'd6);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("strm.s4",    sum, 32'd8);
    chk("strm.v4",    {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    chk("strm.drain", {31'd0, out_valid}, 32'd0);

    // reset with two beats in flight
    a = 32'd10; b = 32'd1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    a = 32'd20; b = 32'd2;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    chk("mrst.pre",   {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst.valid", {31'd0, out_valid}, 32'd0);
    chk("mrst.sum",   sum, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("mrst.stale", {31'd0, out_valid}, 32'd0);
    end
    run_one("mrst.recov", 32'd100, 32'd23, 1'b0, 1'b0, 2'b00, 32'd123, 1'b0, 1'b0, 1'b0);

`ifdef CLA_SATURATE_EN
    run_one("sat_s",   32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 2'b10, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);
    run_one("sat_sn",  32'h8000_0000, 32'h1, 1'b0, 1'b1, 2'b10, 32'h8000_0000, 1'b1, 1'b1, 1'b1);
    run_one("sat_u",   32'h3,         32'h5, 1'b0, 1'b1, 2'b01, 32'h0,         1'b0, 1'b0, 1'b1);
    run_one("sat_ua",  32'hFFFF_FFF0, 32'h20, 1'b0, 1'b0, 2'b01, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);
    run_one("sat_no",  32'h2,         32'h3, 1'b0, 1'b0, 2'b01, 32'h5,         1'b0, 1'b0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
